// File: rtl/shift_pattern_sequencer.sv
// shift_pattern_sequencer
// Streams a captured pattern LSB-first into the shift datapath, one bit per
// shift-enable strobe. All logic runs on clock_50_mhz. A one-cycle strobe
// stands in for the old divided slow clock. The block repeats the pattern for
// a programmed number of passes and counts hits reported by the detector FSM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; counters and match count hold
// S_RUN   | tick counter running, strobe and one bit per TICK_DIV cycles
// S_DRAIN | one cycle so the detector response to the last bit is counted
// S_DONE  | one-cycle done pulse, then back to idle
module shift_pattern_sequencer #(
    parameter int TICK_DIV = 25_000_000,
    parameter int WIDTH    = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clock_50_mhz,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [3:0]       i_passes,
    input  logic             i_detect,
    output logic             o_shift_en,
    output logic             o_shift_bit,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_match_count,
    output logic [3:0]       o_bit_index
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [3:0]        BIT_LAST  = 4'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_pattern;
    logic [3:0]         r_passes;
    logic [3:0]         r_pass_cnt;
    logic [TICK_W-1:0]  r_tick;
    logic [3:0]         r_bit_idx;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_strobe_d;

    logic               w_accept;
    logic               w_tick_tc;
    logic               w_last_bit;
    logic               w_final_pass;
    logic               w_shift_en;
    logic               w_busy;
    logic               w_done;

    assign w_accept     = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_tick_tc    = (r_tick == TICK_LAST);
    assign w_last_bit   = (r_bit_idx == BIT_LAST);
    // passes of zero never matches, which keeps a continuous run going until abort
    assign w_final_pass = (r_passes != 4'd0) && (r_pass_cnt == (r_passes - 4'd1));

    // State register
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe/status decode; abort suppresses strobe and done in its cycle
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_tick_tc) begin
                    w_shift_en = 1'b1;
                    if (w_last_bit && w_final_pass) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_busy       = 1'b1;
                w_next_state = i_abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_done       = !i_abort;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Capture on accept; tick, bit/pass counters and saturating match counter
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern   <= '0;
            r_passes    <= '0;
            r_pass_cnt  <= '0;
            r_tick      <= '0;
            r_bit_idx   <= '0;
            r_match_cnt <= '0;
            r_strobe_d  <= 1'b0;
        end else if (w_accept) begin
            r_pattern   <= i_pattern;
            r_passes    <= i_passes;
            r_pass_cnt  <= '0;
            r_tick      <= '0;
            r_bit_idx   <= '0;
            r_match_cnt <= '0;
            r_strobe_d  <= 1'b0;
        end else begin
            r_strobe_d <= w_shift_en;
            if ((r_state == S_RUN) && !i_abort) begin
                r_tick <= w_tick_tc ? '0 : (r_tick + TICK_ONE);
            end
            if (w_shift_en) begin
                if (w_last_bit) begin
                    r_bit_idx  <= '0;
                    r_pass_cnt <= r_pass_cnt + 4'd1;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                end
            end
            // detector output lags the strobe by one cycle
            if (r_strobe_d && i_detect && !i_abort && (r_match_cnt != CNT_MAX)) begin
                r_match_cnt <= r_match_cnt + CNT_ONE;
            end
        end
    end

    assign o_shift_en    = w_shift_en;
    assign o_shift_bit   = w_shift_en & r_pattern[r_bit_idx];
    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_match_count = r_match_cnt;
    assign o_bit_index   = r_bit_idx;

endmodule

// File: tb/tb_shift_pattern_sequencer.sv
// Testbench for shift_pattern_sequencer (TICK_DIV=4, WIDTH=10, CNT_W=4).
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
// Expected behaviour is derived from cycle arithmetic relative to the start
// accept cycle (r = 0): strobe k (1-based) lands at r = 4k and carries
// pattern bit (k-1) mod 10.
module tb_shift_pattern_sequencer;

    logic       clock_50_mhz = 1'b0;
    logic       reset_n      = 1'b0;
    logic       i_start      = 1'b0;
    logic       i_abort      = 1'b0;
    logic [9:0] i_pattern    = '0;
    logic [3:0] i_passes     = '0;
    logic       i_detect     = 1'b0;
    logic       o_shift_en;
    logic       o_shift_bit;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_match_count;
    logic [3:0] o_bit_index;

    int total = 0;
    int bad   = 0;

    always #5 clock_50_mhz = ~clock_50_mhz;

    shift_pattern_sequencer #(
        .TICK_DIV (4),
        .WIDTH    (10),
        .CNT_W    (4)
    ) dut (
        .clock_50_mhz  (clock_50_mhz),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_pattern     (i_pattern),
        .i_passes      (i_passes),
        .i_detect      (i_detect),
        .o_shift_en    (o_shift_en),
        .o_shift_bit   (o_shift_bit),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_match_count (o_match_count),
        .o_bit_index   (o_bit_index)
    );

    function automatic bit f_strobe(int r, int n);
        return (r >= 4) && (r % 4 == 0) && (r / 4 <= n);
    endfunction

    function automatic bit f_bit(logic [9:0] pat, int r);
        int k;
        k = (r / 4 - 1) % 10;
        return pat[k];
    endfunction

    function automatic bit f_busy(int r, int n);
        return (r >= 1) && (r <= 4 * n + 1);
    endfunction

    function automatic bit f_done(int r, int n);
        return r == 4 * n + 2;
    endfunction

    function automatic int f_idx(int r, int n);
        int s;
        s = (r - 1) / 4;
        if (s > n) s = n;
        return s % 10;
    endfunction

    // Full sequence from start accept: per-cycle strobe/bit/busy/done, bit index
    // and match count. mode: 0 random detect, 1 rising-edge detector on the
    // serial stream, 2 detect held high. abort_r/re1/re2 are cycles (0 = none).
    task automatic test_sequence(input string name, input logic [9:0] pat, input logic [3:0] np,
                                 input int mode, input int abort_r, input int re1, input int re2,
                                 input int lim, input int exp_final);
        int         n;
        int         ecnt;
        int         eidx;
        logic       det, prev, obs_se, obs_sb;
        logic       es, eb, ebusy, edone;
        logic [3:0] exp_v, got_v;
        n      = (np == 4'd0) ? 1_000_000 : 10 * int'(np);
        ecnt   = 0;
        det    = 1'b0;
        prev   = 1'b1;
        obs_se = 1'b0;
        obs_sb = 1'b0;
        @(negedge clock_50_mhz);
        i_start   = 1'b1;
        i_abort   = 1'b0;
        i_pattern = pat;
        i_passes  = np;
        i_detect  = 1'b0;
        for (int r = 1; r <= lim; r++) begin
            @(negedge clock_50_mhz);
            i_start   = (r == re1) || (r == re2);
            i_abort   = (r == abort_r);
            i_pattern = 10'($urandom);
            i_passes  = 4'($urandom);
            case (mode)
                0: det = 1'($urandom_range(0, 1));
                1: if (obs_se) begin
                       det  = !prev && obs_sb;
                       prev = obs_sb;
                   end
                default: det = 1'b1;
            endcase
            i_detect = det;
            #1;
            if (abort_r > 0 && r > abort_r) begin
                es = 1'b0; ebusy = 1'b0; edone = 1'b0; eidx = f_idx(abort_r, n);
            end else begin
                es    = f_strobe(r, n) && (r != abort_r);
                ebusy = f_busy(r, n);
                edone = f_done(r, n) && (r != abort_r);
                eidx  = f_idx(r, n);
            end
            eb    = es ? f_bit(pat, r) : 1'b0;
            exp_v = {es, eb, ebusy, edone};
            got_v = {o_shift_en, o_shift_bit, o_busy, o_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s ctl r=%0d got(en,bit,busy,done)=%b exp=%b", name, r, got_v, exp_v);
            end
            total++;
            if (o_bit_index !== 4'(eidx)) begin
                bad++;
                $display("FAIL %s bit_index r=%0d got=%0d exp=%0d", name, r, o_bit_index, eidx);
            end
            total++;
            if (o_match_count !== 4'(ecnt)) begin
                bad++;
                $display("FAIL %s match_count r=%0d got=%0d exp=%0d", name, r, o_match_count, ecnt);
            end
            if (exp_final >= 0 && r == 4 * n + 2) begin
                total++;
                if (o_match_count !== 4'(exp_final)) begin
                    bad++;
                    $display("FAIL %s final_count got=%0d exp=%0d", name, o_match_count, exp_final);
                end
            end
            obs_se = o_shift_en;
            obs_sb = o_shift_bit;
            if (!(abort_r > 0 && r >= abort_r) && f_strobe(r - 1, n) && det && ecnt < 15) ecnt++;
        end
        i_start  = 1'b0;
        i_abort  = 1'b0;
        i_detect = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got_v;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_50_mhz);
            #1;
            got_v = {o_shift_en, o_shift_bit, o_busy, o_done, o_match_count, o_bit_index};
            total++;
            if (got_v !== 12'd0) begin
                bad++;
                $display("FAIL reset_idle cycle=%0d got=%b exp=0", i, got_v);
            end
        end
    endtask

    task automatic test_single_pass();
        test_sequence("single_pass", 10'b10_0110_0110, 4'd1, 1, 0, 0, 0, 46, 3);
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 3; it++) begin
            logic [3:0] np;
            np = 4'($urandom_range(1, 3));
            test_sequence("random_run", 10'($urandom), np, 0, 0, 0, 0, 40 * int'(np) + 4, -1);
        end
    endtask

    task automatic test_saturate_abort();
        test_sequence("saturate_abort", 10'($urandom), 4'd0, 2, 96, 0, 0, 102, -1);
        total++;
        if (o_match_count !== 4'd15) begin
            bad++;
            $display("FAIL saturate_hold got=%0d exp=15", o_match_count);
        end
    endtask

    task automatic test_abort_final();
        test_sequence("abort_final", 10'($urandom), 4'd1, 0, 40, 0, 0, 48, -1);
    endtask

    task automatic test_ignored_start();
        @(negedge clock_50_mhz);
        i_start = 1'b1;
        i_abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_50_mhz);
            i_start = 1'b0;
            i_abort = 1'b0;
            #1;
            total++;
            if ({o_busy, o_shift_en, o_done} !== 3'b000) begin
                bad++;
                $display("FAIL start_with_abort cycle=%0d got(busy,en,done)=%b exp=000",
                         i, {o_busy, o_shift_en, o_done});
            end
        end
        test_sequence("restart_ignored", 10'($urandom), 4'd2, 0, 0, 7, 22, 84, -1);
    endtask

    task automatic test_reset_midrun();
        logic [9:0]  pat;
        logic [11:0] got_v;
        pat = 10'($urandom);
        @(negedge clock_50_mhz);
        i_start   = 1'b1;
        i_pattern = pat;
        i_passes  = 4'd1;
        i_detect  = 1'b1;
        for (int r = 1; r <= 20; r++) begin
            @(negedge clock_50_mhz);
            i_start = 1'b0;
            #1;
            total++;
            if (o_shift_en !== f_strobe(r, 10)) begin
                bad++;
                $display("FAIL midrun_strobe r=%0d got=%b exp=%b", r, o_shift_en, f_strobe(r, 10));
            end
        end
        reset_n = 1'b0;
        #1;
        got_v = {o_shift_en, o_shift_bit, o_busy, o_done, o_match_count, o_bit_index};
        total++;
        if (got_v !== 12'd0) begin
            bad++;
            $display("FAIL midrun_reset got=%b exp=0", got_v);
        end
        @(negedge clock_50_mhz);
        reset_n  = 1'b1;
        i_detect = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_50_mhz);
            #1;
            got_v = {o_shift_en, o_shift_bit, o_busy, o_done, o_match_count, o_bit_index};
            total++;
            if (got_v !== 12'd0) begin
                bad++;
                $display("FAIL post_reset_idle cycle=%0d got=%b exp=0", i, got_v);
            end
        end
        test_sequence("after_reset", pat, 4'd1, 0, 0, 0, 0, 44, -1);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock_50_mhz);
        reset_n = 1'b1;
        test_reset();
        test_single_pass();
        test_random_runs();
        test_saturate_abort();
        test_abort_final();
        test_ignored_start();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
